writeback_buffer: RTL

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

---
 rtl/writeback_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/writeback_buffer.sv
// Writeback buffer: circular FIFO of pending register-file writes drained one per cycle
// into a registered write port, with combinational forwarding over everything still pending.
module writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_data,
    output logic                     RegWrite,
    output logic [4:0]               write,
    output logic [31:0]              write_data,
    input  logic [4:0]               read_reg_1,
    input  logic [4:0]               read_reg_2,
    output logic                     fwd_hit_1,
    output logic                     fwd_hit_2,
    output logic [31:0]              fwd_data_1,
    output logic [31:0]              fwd_data_2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] idx;
    logic          push;
    logic          pop;

    assign in_ready = (count < CW'(DEPTH));
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push     = rst && in_valid && in_ready && (in_rd != 5'd0);
    assign pop      = (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= in_rd;
            data_mem[tail] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            RegWrite   <= 1'b0;
            write      <= 5'd0;
            write_data <= 32'h0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head       <= head + 1'b1;
                RegWrite   <= 1'b1;
                write      <= rd_mem[head];
                write_data <= data_mem[head];
            end else begin
                RegWrite <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins; the output stage is lowest priority.
    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = 32'h0;
        fwd_data_2 = 32'h0;
        idx        = '0;
        if (RegWrite) begin
            if (write == read_reg_1) begin
                fwd_hit_1  = 1'b1;
                fwd_data_1 = write_data;
            end
            if (write == read_reg_2) begin
                fwd_hit_2  = 1'b1;
                fwd_data_2 = write_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < count) begin
                if (rd_mem[idx] == read_reg_1) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = data_mem[idx];
                end
                if (rd_mem[idx] == read_reg_2) begin
                    fwd_hit_2  = 1'b1;
                    fwd_data_2 = data_mem[idx];
                end
            end
        end
        if (read_reg_1 == 5'd0) begin
            fwd_hit_1  = 1'b0;
            fwd_data_1 = 32'h0;
        end
        if (read_reg_2 == 5'd0) begin
            fwd_hit_2  = 1'b0;
            fwd_data_2 = 32'h0;
        end
    end

endmodule
